// File: rtl/gemm_result_collector_pkg.sv
// Shared definitions for GEMM output-stream consumers.
// Holds the drop-counter width and the row-counter sizing helper.
package gemm_result_collector_pkg;

    localparam int DROP_CNT_WIDTH = 8;

    typedef logic [DROP_CNT_WIDTH-1:0] drop_cnt_t;

    // Row counter needs at least one bit even when a matrix is a single row.
    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/gemm_result_bank.sv
// One INPUT_SIZE x SA_SIZE result matrix register bank with per-row write and a full flag.
// The full flag sets on the last-row write and clears when downstream takes the matrix.
module gemm_result_bank
    import gemm_result_collector_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 3,
    parameter int W     = 8,
    parameter int ROW_W = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [ROW_W-1:0]         wr_row,
    input  logic                     wr_last,
    input  logic [COLS*W-1:0]        wr_data,
    input  logic                     rel_en,
    output logic                     full,
    output logic [ROWS*COLS*W-1:0]   data
);

    // Set wins over clear: with a single-row matrix the bank being released
    // can be refilled on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full <= 1'b0;
        end else if (wr_en && wr_last) begin
            full <= 1'b1;
        end else if (rel_en) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (wr_en && (wr_row == ROW_W'(r))) begin
                data[r*COLS*W +: COLS*W] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/gemm_result_collector.sv
// Groups INPUT_SIZE consecutive GEMM result rows into a matrix, ping-pong buffers two
// matrices and hands them downstream on valid/ready; matrices with no free bank are dropped.
module gemm_result_collector
    import gemm_result_collector_pkg::*;
#(
    parameter int SA_SIZE                = 3,
    parameter int INPUT_SIZE             = 2,
    parameter int WEIGHT_ACTIVATION_SIZE = 8
) (
    input  logic                                                 clk,
    input  logic                                                 resetn,
    input  logic                                                 in_valid,
    input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]            in_data,
    output logic                                                 m_valid,
    input  logic                                                 m_ready,
    output logic [INPUT_SIZE*SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0] m_data,
    output logic                                                 overflow,
    output logic [DROP_CNT_WIDTH-1:0]                            drop_count
);

    localparam int W     = WEIGHT_ACTIVATION_SIZE;
    localparam int MAT_W = INPUT_SIZE * SA_SIZE * W;
    localparam int ROW_W = row_width(INPUT_SIZE);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(INPUT_SIZE - 1);

    logic [ROW_W-1:0] wr_row;
    logic             wr_bank;
    logic             rd_bank;
    logic             accept_q;

    logic [1:0]       full;
    logic [MAT_W-1:0] bank_data [2];

    logic row_first;
    logic row_last;
    logic fire;
    logic bank_free;
    logic accept_now;
    logic write;

    assign row_first  = (wr_row == '0);
    assign row_last   = (wr_row == LAST_ROW);
    assign fire       = m_valid && m_ready;
    // A release on this edge of the bank we are about to write frees it in time.
    assign bank_free  = !full[wr_bank] || (fire && (rd_bank == wr_bank));
    assign accept_now = row_first ? bank_free : accept_q;
    assign write      = in_valid && accept_now;

    for (genvar i = 0; i < 2; i++) begin : g_bank
        gemm_result_bank #(
            .ROWS  (INPUT_SIZE),
            .COLS  (SA_SIZE),
            .W     (W),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk     (clk),
            .resetn  (resetn),
            .wr_en   (write && (wr_bank == 1'(i))),
            .wr_row  (wr_row),
            .wr_last (row_last),
            .wr_data (in_data),
            .rel_en  (fire && (rd_bank == 1'(i))),
            .full    (full[i]),
            .data    (bank_data[i])
        );
    end

    assign m_valid = full[rd_bank];
    assign m_data  = bank_data[rd_bank];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_row     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            accept_q   <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (in_valid) begin
                wr_row <= row_last ? '0 : wr_row + ROW_W'(1);
                if (row_first) begin
                    accept_q <= bank_free;
                end
                if (row_last) begin
                    if (accept_now) begin
                        wr_bank <= ~wr_bank;
                    end else begin
                        overflow <= 1'b1;
                        if (drop_count != '1) begin
                            drop_count <= drop_count + DROP_CNT_WIDTH'(1);
                        end
                    end
                end
            end
            if (fire) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

endmodule
